// File: rtl/frame_sched_pkg.sv
// frame_sched_pkg: shared definitions for the per-frame update sequencer.
// Holds the FSM phase encoding, the 3-bit stage index constants, the number
// of game-logic stages and a helper that turns a stage index into a one-hot
// stage vector.
package frame_sched_pkg;

  localparam int N_STAGES = 5;

  // FSM phase; combined with a 3-bit stage index to form the full state.
  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_GO   = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;
  localparam logic [1:0] PH_FIN  = 2'd3;

  // Stage indices in execution order.
  localparam logic [2:0] ST_INPUT   = 3'd0;
  localparam logic [2:0] ST_PADDLE  = 3'd1;
  localparam logic [2:0] ST_BALL    = 3'd2;
  localparam logic [2:0] ST_COLLIDE = 3'd3;
  localparam logic [2:0] ST_SCORE   = 3'd4;

  typedef logic [N_STAGES-1:0] stage_vec_t;

  // One-hot vector for a stage index; out-of-range indices give all zeros.
  function automatic stage_vec_t stage_onehot(input logic [2:0] idx);
    stage_vec_t v;
    case (idx)
      ST_INPUT:   v = 5'b00001;
      ST_PADDLE:  v = 5'b00010;
      ST_BALL:    v = 5'b00100;
      ST_COLLIDE: v = 5'b01000;
      ST_SCORE:   v = 5'b10000;
      default:    v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/frame_scheduler_stage_watchdog.sv
// stage_watchdog: per-stage timeout counter for the frame sequencer.
// Ports:
//   P_CLK, NRST : clock and asynchronous active-low reset
//   clear       : restart the count (driven while a stage's go is issued)
//   enable      : count one cycle (driven while waiting for a stage's done)
//   done        : the awaited stage finished this cycle; suppresses expire
//   expire      : the wait has lasted TIMEOUT cycles without done
module stage_watchdog
  import frame_sched_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic P_CLK,
  input  logic NRST,
  input  logic clear,
  input  logic enable,
  input  logic done,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // Next count: restart on clear, advance while enabled, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CW{1'b0}};
    end else if (enable) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge P_CLK or negedge NRST) begin
    if (!NRST) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count is 0 in the first wait cycle, so hitting CNT_LAST means the
  // stage has had TIMEOUT full wait cycles. A coincident done takes priority.
  assign expire = enable & ~done & (cnt_q == CNT_LAST);

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame sequencer for the pong game-logic units.
// On every FRAME_DIV-th refresh pulse (while running) it strobes each stage's
// go in order and waits for that stage's done, forcing an advance after
// TIMEOUT wait cycles.
// Ports:
//   P_CLK, NRST  : pixel clock, asynchronous active-low reset
//   frame_start  : refresh pulse;  vblank : vertical blanking level
//   run          : game running;   stage_done[4:0] : per-stage completion
//   clear_err    : clears the sticky error flags
//   stage_go     : one-cycle go per stage;  busy : sequence in progress
//   seq_done     : one-cycle pulse at sequence end;  frame_cnt : launches
//   overrun, late, timeout_err : sticky error flags
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int FRAME_DIV = 1,
  parameter int TIMEOUT   = 64,
  parameter int FCNT_W    = 16
) (
  input  logic              P_CLK,
  input  logic              NRST,
  input  logic              frame_start,
  input  logic              vblank,
  input  logic              run,
  input  logic [4:0]        stage_done,
  input  logic              clear_err,
  output logic [4:0]        stage_go,
  output logic              busy,
  output logic              seq_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              overrun,
  output logic              late,
  output logic [4:0]        timeout_err
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic [1:0]        phase_d, phase_q;
  logic [2:0]        stage_d, stage_q;
  logic [7:0]        div_d, div_q;
  logic [FCNT_W-1:0] frame_cnt_d, frame_cnt_q;
  logic [4:0]        stage_go_d, stage_go_q;
  logic              busy_d, busy_q;
  logic              seq_done_d, seq_done_q;
  logic              overrun_d, overrun_q;
  logic              late_d, late_q;
  logic [4:0]        timeout_err_d, timeout_err_q;
  logic              vblank_q;

  logic              cur_done_s;
  logic              wd_expire_s;
  logic [4:0]        tmo_set_s;

  // Only the done bit of the stage currently in progress matters.
  assign cur_done_s = |(stage_done & stage_onehot(stage_q));

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .P_CLK  (P_CLK),
    .NRST   (NRST),
    .clear  (phase_q == PH_GO),
    .enable (phase_q == PH_WAIT),
    .done   (cur_done_s),
    .expire (wd_expire_s)
  );

  // Sequencer next-state, divider, launch counter and output decode.
  always_comb begin
    phase_d     = phase_q;
    stage_d     = stage_q;
    div_d       = div_q;
    frame_cnt_d = frame_cnt_q;
    tmo_set_s   = 5'b00000;
    case (phase_q)
      PH_IDLE: begin
        if (frame_start && run) begin
          if (div_q == DIV_LAST) begin
            div_d       = 8'd0;
            phase_d     = PH_GO;
            stage_d     = ST_INPUT;
            frame_cnt_d = frame_cnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
          end else begin
            div_d = div_q + 8'd1;
          end
        end else begin
          div_d = div_q;
        end
      end
      PH_GO: begin
        phase_d = PH_WAIT;
      end
      PH_WAIT: begin
        if (cur_done_s || wd_expire_s) begin
          // Expire is already masked by done, so an error means a real timeout.
          if (wd_expire_s) begin
            tmo_set_s = stage_onehot(stage_q);
          end else begin
            tmo_set_s = 5'b00000;
          end
          if (stage_q == ST_SCORE) begin
            phase_d = PH_FIN;
          end else begin
            phase_d = PH_GO;
            stage_d = stage_q + 3'd1;
          end
        end else begin
          phase_d = PH_WAIT;
        end
      end
      PH_FIN: begin
        phase_d = PH_IDLE;
        stage_d = ST_INPUT;
      end
      default: begin
        phase_d = PH_IDLE;
        stage_d = ST_INPUT;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up with it.
    stage_go_d = (phase_d == PH_GO) ? stage_onehot(stage_d) : 5'b00000;
    busy_d     = (phase_d != PH_IDLE);
    seq_done_d = (phase_d == PH_FIN);

    // Sticky flags: a set in the same cycle as clear_err survives the clear.
    overrun_d     = (overrun_q & ~clear_err) | (frame_start & busy_q);
    late_d        = (late_q & ~clear_err) | (vblank_q & ~vblank & busy_q);
    timeout_err_d = (timeout_err_q & {5{~clear_err}}) | tmo_set_s;
  end

  // State and output registers.
  always_ff @(posedge P_CLK or negedge NRST) begin
    if (!NRST) begin
      phase_q       <= PH_IDLE;
      stage_q       <= ST_INPUT;
      div_q         <= 8'd0;
      frame_cnt_q   <= {FCNT_W{1'b0}};
      stage_go_q    <= 5'b00000;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
      overrun_q     <= 1'b0;
      late_q        <= 1'b0;
      timeout_err_q <= 5'b00000;
      vblank_q      <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      stage_q       <= stage_d;
      div_q         <= div_d;
      frame_cnt_q   <= frame_cnt_d;
      stage_go_q    <= stage_go_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
      overrun_q     <= overrun_d;
      late_q        <= late_d;
      timeout_err_q <= timeout_err_d;
      vblank_q      <= vblank;
    end
  end

  assign stage_go    = stage_go_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign frame_cnt   = frame_cnt_q;
  assign overrun     = overrun_q;
  assign late        = late_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/frame_scheduler.md
Name: frame_scheduler

Overview:
Per-frame update sequencer for the pong datapath. On each vertical-refresh pulse it runs the game-logic update units in a fixed order (input sample, paddle move, ball move, collision resolve, score update). Each unit gets a one-cycle go strobe and the sequencer waits for that unit's done before starting the next. It sits between the LCD timing counters and the game-logic units, and it reports overrun, late-completion and per-stage timeout errors.

Parameters:
FRAME_DIV, 1, run one update sequence every FRAME_DIV refresh pulses (game-speed divider, legal range 1..255)
TIMEOUT, 64, maximum cycles to wait for a stage's done before forcing an advance (legal range 2..1023)
FCNT_W, 16, width of the frame counter

Ports:
P_CLK  in  1  pixel clock
NRST  in  1  asynchronous, active-low reset
frame_start  in  1  one-cycle refresh pulse, issued at the first vertical-blank line
vblank  in  1  high while in vertical blanking
run  in  1  game running (GAME_START state); low means pause
stage_done  in  5  per-stage completion; bit i belongs to stage i
clear_err  in  1  one-cycle pulse that clears the sticky error flags
stage_go  out  5  one-cycle start strobe per stage; at most one bit high
busy  out  1  high from the first go until the sequence completes
seq_done  out  1  one-cycle pulse when the last stage finishes
frame_cnt  out  FCNT_W  number of sequences launched; wraps at all-ones
overrun  out  1  sticky; frame_start arrived while busy
late  out  1  sticky; vblank fell while busy
timeout_err  out  5  sticky per-stage timeout flags

Behaviour:
- Reset (asynchronous, NRST low):
  - state IDLE; all outputs 0.
  - Divider counter and timeout counter 0.
  - Applies immediately, even mid-sequence; no go or seq_done is emitted afterwards until a new launch.
- States:
  - IDLE
  - GO_i: one cycle, drives stage_go[i]=1.
  - WAIT_i: stage_go=0.
  - FIN: one cycle, drives seq_done=1.
  - Stages are i=0..4.
- Launch:
  - In IDLE, frame_start=1 with run=1 increments the divider.
  - If the divider equals FRAME_DIV-1, it clears to 0 and the block goes to GO_0; stage_go[0] rises the cycle after frame_start.
  - frame_cnt increments in that same cycle.
  - With FRAME_DIV=1, every pulse launches.
  - frame_start with run=0: ignored; the divider holds.
- Stage sequencing:
  - GO_i always moves to WAIT_i and clears the timeout counter.
  - stage_done[i] is sampled only in WAIT_i; done asserted during GO_i is ignored.
  - done bits of other stages are ignored.
  - In WAIT_i the timeout counter increments every cycle.
  - stage_done[i]=1 → GO_{i+1}, or FIN when i=4. Next go appears at the following cycle.
  - Counter reaches TIMEOUT-1 without done → set timeout_err[i], advance as if done.
  - Done and timeout in the same cycle: done wins; no error is set.
- FIN → IDLE; seq_done is 1 for exactly this cycle.
- busy = 1 in every GO/WAIT/FIN state.
- Minimum sequence length: 11 cycles from launch to seq_done (done returned the cycle after each go).
- Pause: run falling mid-sequence does not abort; the sequence completes and the block returns to IDLE.
- Overrun:
  - frame_start while busy=1 → overrun=1.
  - The pulse is otherwise dropped: no restart, divider unchanged.
- Late: falling edge of vblank while busy=1 → late=1. Needs a one-flop vblank history.
- Sticky flags:
  - clear_err zeroes overrun, late and timeout_err.
  - A flag set condition in the same cycle as clear_err wins (flag ends at 1).
- frame_cnt wraps from 2^FCNT_W-1 to 0 without any flag.
- All outputs are registered.

Decomposition:
- Shared package frame_sched_pkg holds:
  - state encoding (IDLE, GO, WAIT, FIN plus a 3-bit stage index)
  - stage index constants ST_INPUT=0, ST_PADDLE=1, ST_BALL=2, ST_COLLIDE=3, ST_SCORE=4
  - N_STAGES=5
- One sub-module: stage_watchdog.
  - Inputs: clear, enable, done.
  - Outputs: expire.
  - Parameter: TIMEOUT.
  - Counter width $clog2(TIMEOUT).
- Everything else lives in the top FSM.

Test Plan:
1. FRAME_DIV=1, run=1; each stage_done returned 1 cycle after its go; frame_start at cycle 10 → go[0..4] at cycles 11,13,15,17,19; seq_done at 21; frame_cnt=1; no error flags.
2. FRAME_DIV=3, three frame_start pulses → exactly one sequence, launched after the 3rd pulse; with run=0, a 4th pulse leaves the divider unchanged.
3. Stage 2 never returns done, TIMEOUT=64 → go[3] appears 65 cycles after go[2]; timeout_err=5'b00100; the sequence completes.
4. frame_start while busy in WAIT_1 → overrun=1; no restart; frame_cnt unchanged. clear_err together with a new overrun event → overrun stays 1.
5. vblank deasserts during WAIT_3 → late=1; done[3] still advances the sequence normally. NRST pulsed low during WAIT_1 → all outputs 0 at once; no further go until the next launching frame_start.
6. done[2] asserted during GO_2 and deasserted in WAIT_2 → not accepted; stage 2 times out. done for stage i and timeout expiry in the same cycle → timeout_err[i] stays 0.
